adbg_wb_burst_ctrl: RTL and testbench

//  Burst sequencer in the biu_clk domain, sitting in front of the Wishbone BIU.

---
 rtl/adbg_wb_burst_pkg.sv | 28 ++
 rtl/adbg_wb_burst_crc32.sv | 24 ++
 rtl/adbg_wb_burst_ctrl.sv | 134 +++++++++++++
 tb/tb_adbg_wb_burst_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adbg_wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst sequencer:
// FSM state encoding, word-size codes and CRC-32 constants.
package adbg_wb_burst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [3:0] WS_BYTE = 4'd1;
   localparam logic [3:0] WS_HALF = 4'd2;
   localparam logic [3:0] WS_WORD = 4'd4;

   localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

   // Unknown size codes behave as full words.
   function automatic logic [2:0] word_step(input logic [3:0] ws);
      case (ws)
         WS_BYTE: return 3'd1;
         WS_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/adbg_wb_burst_crc32.sv
// Combinational CRC-32 update (reflected polynomial) consuming one 32-bit word
// LSB first. Only used when ADBG_WB_BURST_CRC_EN is defined.
module adbg_wb_burst_crc32
   import adbg_wb_burst_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [31:0] data,
   output logic [31:0] crc_out
);

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 32; i++) begin
         fb = r[0] ^ d[i];
         r  = (r >> 1) ^ (fb ? CRC32_POLY : 32'h0);
      end
      return r;
   endfunction

   assign crc_out = crc_step(crc_in, data);

endmodule

// File: rtl/adbg_wb_burst_ctrl.sv
// Burst sequencer in front of the Wishbone BIU: one command becomes a run of
// single BIU accesses. Optional running CRC-32 under `ADBG_WB_BURST_CRC_EN.
module adbg_wb_burst_ctrl
   import adbg_wb_burst_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int CNT_WIDTH   = 16,
   parameter bit STOP_ON_ERR = 1'b1
) (
   input  logic                  biu_clk,
   input  logic                  biu_rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_rw,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [3:0]            cmd_word_size,
   input  logic [CNT_WIDTH-1:0]  cmd_count,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  biu_strb,
   output logic                  biu_rw,
   output logic [ADDR_WIDTH-1:0] biu_addr,
   output logic [3:0]            biu_word_size,
   output logic [DATA_WIDTH-1:0] biu_di,
   input  logic [DATA_WIDTH-1:0] biu_do,
   input  logic                  biu_rdy,
`ifdef ADBG_WB_BURST_CRC_EN
   output logic [31:0]           crc_o,
`endif
   input  logic                  biu_err
);

   state_t                 state;
   logic [CNT_WIDTH-1:0]   remaining;
   logic                   can_issue;
   logic                   complete;

   // A read may only be strobed when the single read holding slot is free
   // or is being emptied in the same cycle.
   assign can_issue = biu_rw ? (!rd_valid || rd_ready) : wr_valid;
   assign biu_strb  = (state == ST_ISSUE) && biu_rdy && can_issue;
   assign wr_ready  = biu_strb && !biu_rw;
   assign biu_di    = wr_data;
   assign complete  = (state == ST_WAIT) && biu_rdy;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   always_ff @(posedge biu_clk) begin
      if (!biu_rstn) begin
         state         <= ST_IDLE;
         remaining     <= '0;
         err           <= 1'b0;
         rd_valid      <= 1'b0;
         rd_data       <= '0;
         biu_addr      <= '0;
         biu_rw        <= 1'b1;
         biu_word_size <= WS_WORD;
      end else begin
         if (rd_valid && rd_ready)
            rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  biu_rw        <= cmd_rw;
                  biu_addr      <= cmd_addr;
                  biu_word_size <= cmd_word_size;
                  remaining     <= cmd_count;
                  err           <= 1'b0;
                  state         <= (cmd_count == '0) ? ST_DONE : ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (biu_strb)
                  state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (biu_rdy) begin
                  err <= err | biu_err;
                  // A new word overrides a same-cycle rd_ready drain.
                  if (biu_rw) begin
                     rd_data  <= biu_do;
                     rd_valid <= 1'b1;
                  end
                  remaining <= remaining - CNT_WIDTH'(1);
                  biu_addr  <= biu_addr + ADDR_WIDTH'(word_step(biu_word_size));
                  if (remaining == CNT_WIDTH'(1) || (biu_err && STOP_ON_ERR))
                     state <= ST_DONE;
                  else
                     state <= ST_ISSUE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ADBG_WB_BURST_CRC_EN
   logic [31:0] crc_q;
   logic [31:0] crc_next;
   logic [31:0] crc_data;

   assign crc_data = biu_rw ? biu_do : wr_data;

   adbg_wb_burst_crc32 u_crc (
      .crc_in  (crc_q),
      .data    (crc_data),
      .crc_out (crc_next)
   );

   // Writes fold in at BIU accept, reads at completion.
   always_ff @(posedge biu_clk) begin
      if (!biu_rstn)
         crc_q <= CRC32_INIT;
      else if (state == ST_IDLE && cmd_valid)
         crc_q <= CRC32_INIT;
      else if (wr_ready || (complete && biu_rw))
         crc_q <= crc_next;
   end

   assign crc_o = crc_q;
`endif

endmodule

// File: tb/tb_adbg_wb_burst_ctrl.sv
// Scoreboard bench for adbg_wb_burst_ctrl: two instances (STOP_ON_ERR=1 and 0)
// each with its own fixed-latency BIU model. CRC checks need ADBG_WB_BURST_CRC_EN.
module tb_adbg_wb_burst_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_rw;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_word_size;
   logic [15:0] cmd_count;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        rd_ready;

   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic        wr_ready  [2];
   logic        rd_valid  [2];
   logic        busy      [2];
   logic        done      [2];
   logic        err       [2];
   logic        biu_strb  [2];
   logic        biu_rw    [2];
   logic        biu_rdy   [2];
   logic        biu_err   [2];
   logic [31:0] rd_data   [2];
   logic [31:0] biu_addr  [2];
   logic [31:0] biu_di    [2];
   logic [31:0] biu_do    [2];
   logic [3:0]  biu_word_size [2];
`ifdef ADBG_WB_BURST_CRC_EN
   logic [31:0] crc [2];
`endif

   int          err_target [2];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_addr [$];
   logic [31:0] exp_rd   [$];
   logic [31:0] wr_q     [$];
   logic        exp_rw;
   logic [3:0]  exp_ws;
   int          n_strb, n_strb1, n_rd, n_wr, n_done, n_done1, blocked_strb, stalls;

   always #5 clk = ~clk;

   function automatic logic [31:0] model_data(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Reference CRC: xor the word in, then 32 reflected shifts.
   function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [31:0] d);
      logic [31:0] r;
      r = c ^ d;
      for (int i = 0; i < 32; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        rdy_q;
      logic        err_q;
      logic [1:0]  lat;
      logic [31:0] data_q;
      int          strb_n = 0;

      adbg_wb_burst_ctrl #(.STOP_ON_ERR(g == 0)) dut (
         .biu_clk       (clk),
         .biu_rstn      (rstn),
         .cmd_valid     (cmd_valid[g]),
         .cmd_ready     (cmd_ready[g]),
         .cmd_rw        (cmd_rw),
         .cmd_addr      (cmd_addr),
         .cmd_word_size (cmd_word_size),
         .cmd_count     (cmd_count),
         .wr_valid      (wr_valid),
         .wr_ready      (wr_ready[g]),
         .wr_data       (wr_data),
         .rd_valid      (rd_valid[g]),
         .rd_ready      (rd_ready),
         .rd_data       (rd_data[g]),
         .busy          (busy[g]),
         .done          (done[g]),
         .err           (err[g]),
         .biu_strb      (biu_strb[g]),
         .biu_rw        (biu_rw[g]),
         .biu_addr      (biu_addr[g]),
         .biu_word_size (biu_word_size[g]),
         .biu_di        (biu_di[g]),
         .biu_do        (biu_do[g]),
         .biu_rdy       (biu_rdy[g]),
`ifdef ADBG_WB_BURST_CRC_EN
         .crc_o         (crc[g]),
`endif
         .biu_err       (biu_err[g])
      );

      // BIU model: rdy drops after accept, returns 3 cycles later with data.
      always @(posedge clk) begin
         if (!rstn) begin
            rdy_q <= 1'b1;
            lat   <= 2'd0;
            err_q <= 1'b0;
         end else if (biu_strb[g] && rdy_q) begin
            rdy_q  <= 1'b0;
            lat    <= 2'd2;
            strb_n <= strb_n + 1;
            err_q  <= (strb_n + 1 == err_target[g]);
            data_q <= model_data(biu_addr[g]);
         end else if (!rdy_q) begin
            if (lat == 2'd0) rdy_q <= 1'b1;
            else             lat   <= lat - 2'd1;
         end
      end

      assign biu_rdy[g] = rdy_q;
      assign biu_err[g] = rdy_q & err_q;
      assign biu_do[g]  = data_q;
   end

   task automatic issue(input bit both, input logic rw, input logic [31:0] addr,
                        input logic [3:0] ws, input logic [15:0] cnt);
      @(negedge clk);
      cmd_rw        = rw;
      cmd_addr      = addr;
      cmd_word_size = ws;
      cmd_count     = cnt;
      cmd_valid[0]  = 1'b1;
      cmd_valid[1]  = both;
      exp_rw        = rw;
      exp_ws        = ws;
   endtask

   // Runs until done pulses, checking strobes and read beats against the queues.
   task automatic run_burst(input bit both, input int hold_from, input int hold_len);
      int          c = 0;
      bit          seen0 = 0;
      bit          seen1;
      logic [31:0] a;
      seen1 = !both;
      n_strb = 0; n_strb1 = 0; n_rd = 0; n_wr = 0; n_done = 0; n_done1 = 0;
      blocked_strb = 0; stalls = 0;
      while (!(seen0 && seen1) && c < 300) begin
         @(negedge clk);
         cmd_valid[0] = 1'b0;
         cmd_valid[1] = 1'b0;
         rd_ready = !(c >= hold_from && c < hold_from + hold_len);
         wr_valid = (wr_q.size() != 0);
         wr_data  = wr_valid ? wr_q[0] : 32'h0;
         #1;
         if (biu_strb[0]) begin
            n_strb++;
            checks++;
            if (exp_addr.size() == 0) begin
               errors++;
               $display("FAIL strb_unexpected addr=%h (no strobe expected)", biu_addr[0]);
            end else begin
               a = exp_addr.pop_front();
               if (biu_addr[0] !== a || biu_rw[0] !== exp_rw || biu_word_size[0] !== exp_ws) begin
                  errors++;
                  $display("FAIL strb_fields got addr=%h rw=%b ws=%0d want addr=%h rw=%b ws=%0d",
                           biu_addr[0], biu_rw[0], biu_word_size[0], a, exp_rw, exp_ws);
               end
            end
            if (biu_rw[0] && rd_valid[0] && !rd_ready) blocked_strb++;
            if (!biu_rw[0]) begin
               checks++;
               if (biu_di[0] !== wr_data) begin
                  errors++;
                  $display("FAIL biu_di got=%h want=%h", biu_di[0], wr_data);
               end
            end
         end
         if (rd_valid[0] && !rd_ready) stalls++;
         if (wr_ready[0]) begin
            n_wr++;
            a = wr_q.pop_front();
         end
         if (rd_valid[0] && rd_ready) begin
            n_rd++;
            checks++;
            if (exp_rd.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected data=%h (no read expected)", rd_data[0]);
            end else begin
               a = exp_rd.pop_front();
               if (rd_data[0] !== a) begin
                  errors++;
                  $display("FAIL rd_data got=%h want=%h", rd_data[0], a);
               end
            end
         end
         if (biu_strb[1]) n_strb1++;
         if (done[0]) begin n_done++;  seen0 = 1; end
         if (done[1]) begin n_done1++; seen1 = 1; end
         c++;
      end
      checks++;
      if (!(seen0 && seen1)) begin
         errors++;
         $display("FAIL burst_timeout got done=%b/%b after %0d cycles want done", seen0, seen1, c);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         wr_valid = 1'b0;
         rd_ready = 1'b1;
         #1;
         if (done[0])     n_done++;
         if (done[1])     n_done1++;
         if (biu_strb[0]) n_strb++;
      end
      checks++;
      if (exp_addr.size() != 0 || exp_rd.size() != 0) begin
         errors++;
         $display("FAIL leftover got addr_q=%0d rd_q=%0d want 0/0", exp_addr.size(), exp_rd.size());
         exp_addr.delete();
         exp_rd.delete();
      end
   endtask

   task automatic test_reset;
      logic [31:0] got [9];
      logic [31:0] want [9];
      rstn = 1'b0;
      cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
      cmd_rw = 1'b0; cmd_addr = '0; cmd_word_size = '0; cmd_count = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
      err_target[0] = 0; err_target[1] = 0;
      repeat (3) @(negedge clk);
      #1;
      got  = '{32'(busy[0]), 32'(done[0]), 32'(err[0]), 32'(rd_valid[0]), 32'(biu_strb[0]),
               rd_data[0], biu_addr[0], 32'(biu_rw[0]), 32'(cmd_ready[0])};
      want = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL reset_value[%0d] got=%h want=%h", i, got[i], want[i]);
         end
      end
`ifdef ADBG_WB_BURST_CRC_EN
      checks++;
      if (crc[0] !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL reset_crc got=%h want=ffffffff", crc[0]);
      end
`endif
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_read_burst;
      for (int i = 0; i < 4; i++) begin
         exp_addr.push_back(32'h100 + 32'(4 * i));
         exp_rd.push_back(model_data(32'h100 + 32'(4 * i)));
      end
      issue(0, 1'b1, 32'h100, 4'd4, 16'd4);
      run_burst(0, 1000, 0);
      checks++; if (n_strb !== 4) begin errors++; $display("FAIL rd4_strobes got=%0d want=4", n_strb); end
      checks++; if (n_rd !== 4)   begin errors++; $display("FAIL rd4_beats got=%0d want=4", n_rd); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL rd4_done got=%0d want=1", n_done); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL rd4_err got=%b want=0", err[0]); end
   endtask

   task automatic test_write_wrap;
      exp_addr.push_back(32'hFFFF_FFFE);
      exp_addr.push_back(32'h0000_0000);
      exp_addr.push_back(32'h0000_0002);
      wr_q.push_back(32'h0000_A1B2);
      wr_q.push_back(32'h0000_C3D4);
      wr_q.push_back(32'h0000_E5F6);
      issue(0, 1'b0, 32'hFFFF_FFFE, 4'd2, 16'd3);
      run_burst(0, 1000, 0);
      checks++; if (n_wr !== 3)   begin errors++; $display("FAIL wr_beats got=%0d want=3", n_wr); end
      checks++; if (n_strb !== 3) begin errors++; $display("FAIL wr_strobes got=%0d want=3", n_strb); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL wr_done got=%0d want=1", n_done); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL wr_err got=%b want=0", err[0]); end
      wr_q.delete();
   endtask

   task automatic test_error_stop;
      err_target[0] = g_dut[0].strb_n + 2;
      err_target[1] = g_dut[1].strb_n + 2;
      for (int i = 0; i < 2; i++) begin
         exp_addr.push_back(32'h200 + 32'(4 * i));
         exp_rd.push_back(model_data(32'h200 + 32'(4 * i)));
      end
      issue(1, 1'b1, 32'h200, 4'd4, 16'd5);
      run_burst(1, 1000, 0);
      checks++; if (n_strb !== 2)  begin errors++; $display("FAIL stop_strobes got=%0d want=2", n_strb); end
      checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL stop_err got=%b want=1", err[0]); end
      checks++; if (n_done !== 1)  begin errors++; $display("FAIL stop_done got=%0d want=1", n_done); end
      checks++; if (n_strb1 !== 5) begin errors++; $display("FAIL nostop_strobes got=%0d want=5", n_strb1); end
      checks++; if (err[1] !== 1'b1) begin errors++; $display("FAIL nostop_err got=%b want=1", err[1]); end
      checks++; if (n_done1 !== 1) begin errors++; $display("FAIL nostop_done got=%0d want=1", n_done1); end
      err_target[0] = 0;
      err_target[1] = 0;
   endtask

   task automatic test_rd_backpressure;
      for (int i = 0; i < 6; i++) begin
         exp_addr.push_back(32'h40 + 32'(i));
         exp_rd.push_back(model_data(32'h40 + 32'(i)));
      end
      issue(0, 1'b1, 32'h40, 4'd1, 16'd6);
      run_burst(0, 8, 20);
      checks++; if (blocked_strb !== 0) begin errors++; $display("FAIL bp_strobe_while_full got=%0d want=0", blocked_strb); end
      checks++; if (stalls < 10) begin errors++; $display("FAIL bp_stall_cycles got=%0d want>=10", stalls); end
      checks++; if (n_rd !== 6) begin errors++; $display("FAIL bp_beats got=%0d want=6", n_rd); end
      checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL bp_err_cleared got=%b want=0", err[0]); end
   endtask

   task automatic test_zero_count;
      issue(0, 1'b1, 32'h80, 4'd4, 16'd0);
      #1;
      checks++; if (cmd_ready[0] !== 1'b1) begin errors++; $display("FAIL zc_cmd_ready got=%b want=1", cmd_ready[0]); end
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      #1;
      checks++;
      if (done[0] !== 1'b1 || biu_strb[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL zc_done_cycle got done=%b strb=%b busy=%b want 1/0/1", done[0], biu_strb[0], busy[0]);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done[0] !== 1'b0 || biu_strb[0] !== 1'b0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL zc_after got done=%b strb=%b busy=%b want 0/0/0", done[0], biu_strb[0], busy[0]);
      end
   endtask

`ifdef ADBG_WB_BURST_CRC_EN
   task automatic test_crc;
      logic [31:0] want;
      exp_addr.push_back(32'h500);
      wr_q.push_back(32'h0000_0000);
      issue(0, 1'b0, 32'h500, 4'd4, 16'd1);
      run_burst(0, 1000, 0);
      want = crc_ref(32'hFFFF_FFFF, 32'h0);
      checks++; if (crc[0] !== want) begin errors++; $display("FAIL crc_wr0 got=%h want=%h", crc[0], want); end
      for (int i = 0; i < 2; i++) begin
         exp_addr.push_back(32'h600 + 32'(4 * i));
         exp_rd.push_back(model_data(32'h600 + 32'(4 * i)));
      end
      issue(0, 1'b1, 32'h600, 4'd4, 16'd2);
      run_burst(0, 1000, 0);
      want = crc_ref(crc_ref(32'hFFFF_FFFF, model_data(32'h600)), model_data(32'h604));
      checks++; if (crc[0] !== want) begin errors++; $display("FAIL crc_rd2 got=%h want=%h", crc[0], want); end
   endtask
`endif

   task automatic test_reset_in_wait;
      int          c = 0;
      bit          hit = 0;
      int          dn = 0;
      logic [31:0] got [9];
      logic [31:0] want [9];
      issue(0, 1'b1, 32'h300, 4'd4, 16'd1);
      while (!hit && c < 20) begin
         @(negedge clk);
         cmd_valid[0] = 1'b0;
         #1;
         if (biu_strb[0]) hit = 1;
         c++;
      end
      checks++; if (!hit) begin errors++; $display("FAIL rst_wait_no_strobe got=0 want=1"); end
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      #1;
      got  = '{32'(busy[0]), 32'(done[0]), 32'(err[0]), 32'(rd_valid[0]), 32'(biu_strb[0]),
               rd_data[0], biu_addr[0], 32'(biu_rw[0]), 32'(cmd_ready[0])};
      want = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL rst_wait_value[%0d] got=%h want=%h", i, got[i], want[i]);
         end
      end
      rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         if (done[0]) dn++;
      end
      checks++; if (dn !== 0) begin errors++; $display("FAIL rst_wait_done_pulse got=%0d want=0", dn); end
   endtask

   initial begin
      test_reset();
      test_read_burst();
      test_write_wrap();
      test_error_stop();
      test_rd_backpressure();
      test_zero_count();
`ifdef ADBG_WB_BURST_CRC_EN
      test_crc();
`endif
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
